// File: rtl/serial_add_sub_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_add_sub_if
//  Description : Request/result bundle for the bit-serial adder/subtractor.
//                The sub mode bit exists only when SERIAL_ADD_SUB_SUB_EN is
//                defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface serial_add_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADD_SUB_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    // Requester side: issues operands, observes status and result
    modport master (
        output start, a, b, cin,
`ifdef SERIAL_ADD_SUB_SUB_EN
        output sub,
`endif
        input  busy, done, sum, cout
    );

    // Arithmetic unit side
    modport slave (
        input  start, a, b, cin,
`ifdef SERIAL_ADD_SUB_SUB_EN
        input  sub,
`endif
        output busy, done, sum, cout
    );
endinterface
`default_nettype wire

// File: rtl/serial_add_sub.sv
`default_nettype none
// ============================================================================
//  Module      : serial_add_sub
//  Description : Bit-serial adder. One full-adder cell plus a carry flop
//                resolves WIDTH-bit operands LSB-first, one bit per clock.
//                Optional macro SERIAL_ADD_SUB_SUB_EN adds a sub mode that
//                reuses the cell as a full subtractor (carry becomes borrow).
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input  wire logic           clk,
    input  wire logic           rst,
    serial_add_sub_if.slave     bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] C_CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] C_CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] work;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             bit_s;
    logic             carry_next;
    logic [WIDTH-1:0] work_next;
`ifdef SERIAL_ADD_SUB_SUB_EN
    logic             mode;
`endif

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;

    // Single-bit ALU: sum/difference bit and next carry/borrow for the LSBs
    always_comb begin
        bit_s      = op_a[0] ^ op_b[0] ^ carry;
        carry_next = (op_a[0] & op_b[0]) | ((op_a[0] ^ op_b[0]) & carry);
`ifdef SERIAL_ADD_SUB_SUB_EN
        if (mode) begin
            carry_next = (~op_a[0] & op_b[0]) | (~(op_a[0] ^ op_b[0]) & carry);
        end
`endif
        // Result bits enter at the MSB so bit 0 lands in place after WIDTH shifts
        work_next  = {bit_s, work[WIDTH-1:1]};
    end

    // Control FSM and datapath registers; outputs are registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            carry  <= 1'b0;
            op_a   <= '0;
            op_b   <= '0;
            work   <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            sum_r  <= '0;
            cout_r <= 1'b0;
`ifdef SERIAL_ADD_SUB_SUB_EN
            mode   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        op_a   <= bus.a;
                        op_b   <= bus.b;
                        carry  <= bus.cin;
`ifdef SERIAL_ADD_SUB_SUB_EN
                        mode   <= bus.sub;
`endif
                        cnt    <= '0;
                        busy_r <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    op_a  <= op_a >> 1;
                    op_b  <= op_b >> 1;
                    work  <= work_next;
                    carry <= carry_next;
                    cnt   <= cnt + C_CNT_ONE;
                    // Terminal compare on the last bit index, not on overflow
                    if (cnt == C_CNT_LAST) begin
                        sum_r  <= work_next;
                        cout_r <= carry_next;
                        done_r <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_serial_add_sub.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_add_sub
//  Description : Self-checking bench for serial_add_sub: directed timing,
//                lockout, abort and back-to-back cases plus random operands
//                against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_add_sub;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    serial_add_sub_if #(.WIDTH(WIDTH)) bus ();

    serial_add_sub #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic; bit WIDTH is carry / borrow
    function automatic logic [WIDTH:0] ref_calc(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic cin,
                                                input logic sub);
        int r;
        if (sub) r = int'(a) - int'(b) - int'(cin);
        else     r = int'(a) + int'(b) + int'(cin);
        return (WIDTH+1)'(r);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic cin, input logic sub);
        bus.start = st;
        bus.a     = a;
        bus.b     = b;
        bus.cin   = cin;
`ifdef SERIAL_ADD_SUB_SUB_EN
        bus.sub   = sub;
`else
        if (sub) $display("note: sub requested in add-only build");
`endif
    endtask

    // One full operation with cycle-accurate status checks
    task automatic do_op(input string tag, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic cin, input logic sub);
        logic [WIDTH:0]   exp;
        logic [WIDTH-1:0] prev;
        exp  = ref_calc(a, b, cin, sub);
        prev = bus.sum;
        @(negedge clk);
        drive(1'b1, a, b, cin, sub);
        tick();                                   // accept edge k
        drive(1'b0, ~a, ~b, ~cin, sub);           // operands are don't-care now
        check({tag, ".busy_k"}, 32'(bus.busy), 32'd1);
        for (int i = 1; i < WIDTH; i++) begin
            tick();
            check({tag, ".done_early"}, 32'(bus.done), 32'd0);
            check({tag, ".sum_hold"}, 32'(bus.sum), 32'(prev));
        end
        tick();                                   // edge k+WIDTH
        check({tag, ".done"}, 32'(bus.done), 32'd1);
        check({tag, ".sum"},  32'(bus.sum),  32'(exp[WIDTH-1:0]));
        check({tag, ".cout"}, 32'(bus.cout), 32'(exp[WIDTH]));
        tick();                                   // edge k+WIDTH+1
        check({tag, ".busy_end"}, 32'(bus.busy), 32'd0);
        check({tag, ".done_end"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        logic [WIDTH-1:0] ra, rb;
        logic             rc, rs;
        logic [WIDTH:0]   e;

        drive(1'b0, '0, '0, 1'b0, 1'b0);

        // Reset for two cycles, start low
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst.sum",  32'(bus.sum),  32'd0);
            check("rst.cout", 32'(bus.cout), 32'd0);
            check("rst.busy", 32'(bus.busy), 32'd0);
            check("rst.done", 32'(bus.done), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("idle.busy", 32'(bus.busy), 32'd0);

        // Carry ripple through all bits
        do_op("ripple", 8'hFF, 8'h01, 1'b0, 1'b0);
        check("ripple.sum_abs", 32'(bus.sum), 32'h00);
        check("ripple.cout_abs", 32'(bus.cout), 32'd1);

        // Carry-in, then start held high for a back-to-back second op
        @(negedge clk);
        drive(1'b1, 8'h35, 8'h4A, 1'b1, 1'b0);
        tick();                                   // edge k
        drive(1'b1, 8'h80, 8'h80, 1'b0, 1'b0);
        for (int i = 0; i < WIDTH; i++) tick();   // edge k+8
        check("b2b.done1", 32'(bus.done), 32'd1);
        check("b2b.sum1",  32'(bus.sum),  32'h80);
        check("b2b.cout1", 32'(bus.cout), 32'd0);
        tick();                                   // edge k+9
        check("b2b.busy9", 32'(bus.busy), 32'd0);
        tick();                                   // edge k+10 re-accept
        check("b2b.busy10", 32'(bus.busy), 32'd1);
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < WIDTH; i++) tick();   // edge k+18
        check("b2b.done2", 32'(bus.done), 32'd1);
        check("b2b.sum2",  32'(bus.sum),  32'h00);
        check("b2b.cout2", 32'(bus.cout), 32'd1);
        tick();

        // Busy lockout: start pulse at edge 3 of an op in flight is ignored
        @(negedge clk);
        drive(1'b1, 8'h12, 8'h34, 1'b0, 1'b0);
        tick();                                   // edge 0
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        tick();
        tick();                                   // after edge 2
        drive(1'b1, 8'h0F, 8'h01, 1'b0, 1'b0);
        tick();                                   // edge 3
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        for (int i = 4; i <= WIDTH; i++) tick();  // edge 8
        check("lock.done", 32'(bus.done), 32'd1);
        check("lock.sum",  32'(bus.sum),  32'h46);
        check("lock.cout", 32'(bus.cout), 32'd0);
        tick();
        tick();
        check("lock.noqueue", 32'(bus.busy), 32'd0);

        // Abort: rst on the 4th SHIFT edge of a new op
        @(negedge clk);
        drive(1'b1, 8'hAA, 8'h55, 1'b1, 1'b0);
        tick();                                   // accept
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        tick(); tick(); tick();                   // 3 shift edges
        rst = 1'b1;
        tick();                                   // 4th shift edge, reset
        rst = 1'b0;
        check("abort.busy", 32'(bus.busy), 32'd0);
        check("abort.sum",  32'(bus.sum),  32'd0);
        check("abort.cout", 32'(bus.cout), 32'd0);
        for (int i = 0; i < WIDTH + 2; i++) begin
            tick();
            check("abort.nodone", 32'(bus.done), 32'd0);
        end

`ifdef SERIAL_ADD_SUB_SUB_EN
        do_op("sub1", 8'h10, 8'h01, 1'b0, 1'b1);
        check("sub1.sum_abs", 32'(bus.sum), 32'h0F);
        do_op("sub2", 8'h00, 8'h01, 1'b0, 1'b1);
        check("sub2.sum_abs", 32'(bus.sum), 32'hFF);
        check("sub2.cout_abs", 32'(bus.cout), 32'd1);
        do_op("sub3", 8'h05, 8'h05, 1'b1, 1'b1);
        check("sub3.sum_abs", 32'(bus.sum), 32'hFF);
        check("sub3.cout_abs", 32'(bus.cout), 32'd1);
`endif

        // Random operands against the reference model
        for (int n = 0; n < 40; n++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rc = 1'($urandom);
`ifdef SERIAL_ADD_SUB_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            e = ref_calc(ra, rb, rc, rs);
            do_op("rand", ra, rb, rc, rs);
            check("rand.sum_post", 32'(bus.sum), 32'(e[WIDTH-1:0]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire

// File: doc/serial_add_sub.md
# serial_add_sub

Bit-serial adder that is the arithmetic counterpart of the team's full-subtractor cell. It accepts two WIDTH-bit operands plus a carry-in on a start strobe and resolves them LSB-first through one full-adder cell and a carry flip-flop, one bit per clock. It produces a WIDTH-bit sum and a carry-out with a one-cycle done pulse. It serves area-constrained datapaths that can trade latency for a single-bit ALU, and optionally reuses the same cell for subtraction.

## Interface
- WIDTH, 8, operand/result width in bits (≥ 2)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A, captured when start is accepted
- b  input  WIDTH  operand B, captured when start is accepted
- cin  input  1  carry-in (borrow-in when subtracting), captured with operands
- sub  input  1  exists only with SERIAL_ADD_SUB_SUB_EN; 1 = subtract, captured with operands
- busy  output  1  high in SHIFT and DONE
- done  output  1  one-cycle pulse; result valid
- sum  output  WIDTH  result register
- cout  output  1  carry-out (borrow-out when subtracting)

## Operation
- One clock domain. Reset is synchronous and active-high. Ports are named clk and rst.
- FSM states:
  - IDLE: start=1 loads shift registers A←a, B←b, carry←cin (and mode←sub), clears the bit counter, and goes to SHIFT. start=0 stays in IDLE.
  - SHIFT: each edge computes s = A[0]^B[0]^carry and carry ← A[0]&B[0] | (A[0]^B[0])&carry. s shifts into the MSB of the working sum register; A and B shift right. The counter increments. On the edge processing bit WIDTH-1, the state goes to DONE, sum ← final working register, and cout ← final carry.
  - DONE: done=1 for exactly this cycle. The next edge goes to IDLE unconditionally.
- sum/cout change only on the SHIFT→DONE edge and on reset. They hold their value through IDLE and through the next operation until it completes.
- start is ignored while busy=1: no queueing, no effect on the operation in flight.
- Operand inputs are don't-care except on the accepting edge.
- Result = (a + b + cin) mod 2^WIDTH. cout = bit WIDTH of the full sum.

## Timing
- Reset values: state IDLE, busy=0, done=0, sum=0, cout=0; counter, carry and shift registers are 0.
- Start accepted at edge k (IDLE, start=1):
  - busy=1 from edge k.
  - The bits are processed on edges k+1 … k+WIDTH.
  - sum/cout are valid and done=1 after edge k+WIDTH.
  - Back in IDLE with busy=0 after edge k+WIDTH+1.
- Latency from start edge to done is WIDTH cycles. Throughput is one operation per WIDTH+2 cycles. The earliest next accept is edge k+WIDTH+2.
- start held high continuously produces back-to-back operations at that rate, with operands re-sampled at each accept.
- rst=1 mid-operation aborts on that edge: all reset values apply, the partial result is discarded, and no done pulse occurs.
- rst takes priority over start on the same edge.
- Counter wrap: the counter is ceil(log2(WIDTH)) bits. The terminal compare is against WIDTH-1, never against overflow.

## Configuration
- SERIAL_ADD_SUB_SUB_EN defined:
  - The sub port exists.
  - With mode=1, each SHIFT edge computes d = A[0]^B[0]^carry and carry ← (~A[0]&B[0]) | (~(A[0]^B[0])&carry).
  - Result = (a − b − cin) mod 2^WIDTH. cout is the final borrow.
  - With mode=0, the adder behaviour is unchanged.
- Undefined: no sub port, add-only, identical timing.

## Test plan
- Reset/idle: assert rst for 2 cycles, start=0 → sum=0x00, cout=0, busy=0, done=0 throughout.
- Carry ripple, WIDTH=8: a=0xFF, b=0x01, cin=0, start at edge k → busy from k, done only after edge k+8, sum=0x00, cout=1. busy=0 after edge k+9.
- Carry-in: a=0x35, b=0x4A, cin=1 → sum=0x80, cout=0. Then with start held high, a second op a=0x80, b=0x80, cin=0 is accepted at k+10 → sum=0x00, cout=1.
- Busy lockout and abort:
  - Start pulse with a=0x0F, b=0x01 at edge 3 during an op in flight (accepted at edge 0) → ignored; the first result completes unchanged.
  - rst at the 4th SHIFT edge of a new op → no done pulse, sum=0x00.
- SERIAL_ADD_SUB_SUB_EN, sub=1:
  - a=0x10, b=0x01, cin=0 → sum=0x0F, cout=0.
  - a=0x00, b=0x01, cin=0 → sum=0xFF, cout=1.
  - a=0x05, b=0x05, cin=1 → sum=0xFF, cout=1.
